// File: rtl/byte_memory_arbiter_pkg.sv
// Shared definitions for the two-requester byte-register arbiter:
// FSM encoding, requester IDs and default bus widths.
package byte_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/byte_memory_arbiter_if.sv
// Requester-side bus of the byte-register arbiter: two request channels
// plus the shared grant/ack/read-data return path.
interface byte_memory_arbiter_if
  import byte_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  a_grant;
  logic                  b_grant;
  logic                  a_ack;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_grant, b_grant, a_ack, b_ack, rdata, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_grant, b_grant, a_ack, b_ack, rdata, busy
  );

endinterface

// File: rtl/byte_memory_arbiter_byte_register.sv
// One storage word: D flip-flops with write enable, cleared by reset.
module byte_register
  import byte_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/byte_memory_arbiter.sv
// Round-robin arbiter sharing a small register bank between requesters A and B,
// one read or write per grant, with a 4-phase req/ack handshake.
//   state  | meaning
//   IDLE   | no owner; arbitrate on any request
//   ACCESS | owner latched; perform the single read or write
//   DONE   | ack held until the owner drops its request
module byte_memory_arbiter
  import byte_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic            clock,
  input logic            reset,
  byte_memory_arbiter_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_last;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_a_grant;
  logic                  r_b_grant;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] w_q [DEPTH];
  logic [DEPTH-1:0]      w_wr_en;
  logic                  w_pick;
  logic                  w_owner_req;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // On a tie the requester not served last wins; otherwise the sole requester.
  assign w_pick      = (bus.a_req && bus.b_req) ? ~r_last : (bus.b_req ? REQ_B : REQ_A);
  assign w_owner_req = (r_owner == REQ_A) ? bus.a_req : bus.b_req;
  assign w_sel_we    = (w_pick == REQ_A) ? bus.a_we    : bus.b_we;
  assign w_sel_addr  = (w_pick == REQ_A) ? bus.a_addr  : bus.b_addr;
  assign w_sel_wdata = (w_pick == REQ_A) ? bus.a_wdata : bus.b_wdata;

  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    assign w_wr_en[g] = (r_state == ACCESS) && r_we && (r_addr == ADDR_WIDTH'(g));
    byte_register #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .i_clk (clock),
      .i_rst (reset),
      .i_we  (w_wr_en[g]),
      .i_d   (r_wdata),
      .o_q   (w_q[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= REQ_A;
      r_last    <= REQ_B;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_a_grant <= 1'b0;
      r_b_grant <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            r_owner   <= w_pick;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_a_grant <= (w_pick == REQ_A);
            r_b_grant <= (w_pick == REQ_B);
            r_busy    <= 1'b1;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_rdata <= r_we ? r_wdata : w_q[r_addr];
          r_a_ack <= (r_owner == REQ_A);
          r_b_ack <= (r_owner == REQ_B);
          r_state <= DONE;
        end
        DONE: begin
          if (!w_owner_req) begin
            r_a_grant <= 1'b0;
            r_b_grant <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= r_owner;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_grant = r_a_grant;
  assign bus.b_grant = r_b_grant;
  assign bus.a_ack   = r_a_ack;
  assign bus.b_ack   = r_b_ack;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_byte_memory_arbiter.sv
// Self-checking bench for byte_memory_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_byte_memory_arbiter;
  import byte_mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  byte_memory_arbiter_if bus ();

  byte_memory_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_mem [4];
  bit         m_last;

  // status word: {a_grant, b_grant, a_ack, b_ack, busy}
  wire [4:0] st = {bus.a_grant, bus.b_grant, bus.a_ack, bus.b_ack, bus.busy};

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      vectors++;
      if ((bus.a_grant && bus.b_grant) || (bus.a_ack && !bus.a_grant) || (bus.b_ack && !bus.b_grant)) begin
        miscompares++;
        $display("FAIL invariant t=%0t status=%b", $time, st);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic bit model_pick(bit a, bit b);
    if (a && b) return !m_last;
    return b;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_last = 1'b1;
  endtask

  task automatic set_a(bit req, bit we, logic [1:0] addr, logic [7:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(bit req, bit we, logic [1:0] addr, logic [7:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  // Requests are already on the bus and the arbiter is idle before the next edge.
  task automatic serve(bit own, int hold, bit poke_other, bit scramble);
    bit         we;
    logic [1:0] addr;
    logic [7:0] wd, exp;
    logic [4:0] exp_g, exp_k;
    we    = own ? bus.b_we    : bus.a_we;
    addr  = own ? bus.b_addr  : bus.a_addr;
    wd    = own ? bus.b_wdata : bus.a_wdata;
    exp   = we ? wd : m_mem[addr];
    exp_g = own ? 5'b01001 : 5'b10001;
    exp_k = own ? 5'b01011 : 5'b10101;
    tick;
    vectors++;
    if (st !== exp_g) begin
      miscompares++;
      $display("FAIL grant owner=%0d status=%b required=%b", own, st, exp_g);
    end
    if (scramble) begin
      if (own) begin bus.b_we = ~we; bus.b_addr = 2'($urandom); bus.b_wdata = 8'($urandom); end
      else     begin bus.a_we = ~we; bus.a_addr = 2'($urandom); bus.a_wdata = 8'($urandom); end
    end
    if (poke_other) begin
      if (own) set_a(1'b1, 1'b0, 2'($urandom), 8'($urandom));
      else     set_b(1'b1, 1'b0, 2'($urandom), 8'($urandom));
    end
    tick;
    vectors++;
    if (st !== exp_k || bus.rdata !== exp) begin
      miscompares++;
      $display("FAIL ack owner=%0d status=%b rdata=%h required=%b/%h", own, st, bus.rdata, exp_k, exp);
    end
    if (we) m_mem[addr] = wd;
    for (int h = 0; h < hold; h++) begin
      tick;
      vectors++;
      if (st !== exp_k || bus.rdata !== exp) begin
        miscompares++;
        $display("FAIL hold owner=%0d status=%b rdata=%h required=%b/%h", own, st, bus.rdata, exp_k, exp);
      end
    end
    if (own) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    tick;
    vectors++;
    if (st !== 5'b00000) begin
      miscompares++;
      $display("FAIL release owner=%0d status=%b required=00000", own, st);
    end
    m_last = own;
  endtask

  task automatic test_reset;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    reset = 1'b1;
    tick; tick;
    model_clear();
    vectors++;
    if (st !== 5'b00000 || bus.rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset status=%b rdata=%h required=00000/00", st, bus.rdata);
    end
    reset = 1'b0;
    tick;
    vectors++;
    if (st !== 5'b00000) begin
      miscompares++;
      $display("FAIL idle status=%b required=00000", st);
    end
  endtask

  task automatic test_write_read;
    set_a(1, 1, 2'd2, 8'hA5);
    serve(REQ_A, 1, 0, 0);
    set_b(1, 0, 2'd2, 8'h00);
    serve(REQ_B, 0, 0, 0);
    set_b(1, 0, 2'd1, 8'h00);
    serve(REQ_B, 2, 0, 0);
    vectors++;
    if (m_mem[2] !== 8'hA5 || m_mem[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL model_bank got=%h/%h required=a5/00", m_mem[2], m_mem[1]);
    end
  endtask

  task automatic test_tie;
    m_last = 1'b1;
    set_a(1, 0, 2'd2, 0);
    set_b(1, 0, 2'd1, 0);
    serve(model_pick(1, 1), 1, 0, 0);
    serve(REQ_B, 0, 0, 0);
    set_a(1, 1, 2'd0, 8'h11);
    set_b(1, 1, 2'd3, 8'h22);
    serve(model_pick(1, 1), 0, 0, 0);
    serve(REQ_B, 0, 0, 0);
  endtask

  task automatic test_nonowner;
    set_a(1, 0, 2'd2, 0);
    serve(REQ_A, 2, 1, 0);
    serve(REQ_B, 0, 0, 0);
  endtask

  task automatic test_drop_in_access;
    set_a(1, 1, 2'd3, 8'h3C);
    tick;
    vectors++;
    if (st !== 5'b10001) begin
      miscompares++;
      $display("FAIL drop_grant status=%b required=10001", st);
    end
    bus.a_req = 1'b0;
    tick;
    vectors++;
    if (st !== 5'b10101 || bus.rdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL drop_ack status=%b rdata=%h required=10101/3c", st, bus.rdata);
    end
    tick;
    vectors++;
    if (st !== 5'b00000) begin
      miscompares++;
      $display("FAIL drop_release status=%b required=00000", st);
    end
    m_mem[3] = 8'h3C;
    m_last   = REQ_A;
    set_b(1, 0, 2'd3, 0);
    serve(REQ_B, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    set_a(1, 1, 2'd0, 8'h77);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    vectors++;
    if (st !== 5'b00000 || bus.rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid status=%b rdata=%h required=00000/00", st, bus.rdata);
    end
    reset = 1'b0;
    model_clear();
    set_a(1, 0, 2'd0, 0);
    set_b(1, 0, 2'd0, 0);
    serve(model_pick(1, 1), 0, 0, 0);
    serve(REQ_B, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [1:0] r;
      bit own;
      r = 2'($urandom_range(1, 3));
      set_a(r[0], 1'($urandom), 2'($urandom), 8'($urandom));
      set_b(r[1], 1'($urandom), 2'($urandom), 8'($urandom));
      own = model_pick(r[0], r[1]);
      serve(own, int'($urandom_range(0, 3)), 0, 1'($urandom));
      if (r == 2'b11) begin
        if ($urandom_range(0, 1) == 1) begin
          serve(!own, int'($urandom_range(0, 2)), 0, 1'($urandom));
        end else begin
          bus.a_req = 1'b0;
          bus.b_req = 1'b0;
          tick;
          vectors++;
          if (st !== 5'b00000) begin
            miscompares++;
            $display("FAIL not_queued status=%b required=00000", st);
          end
        end
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_tie();
    test_nonowner();
    test_drop_in_access();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
